// File: rtl/hps_vram_wr_buffer.sv
// -----------------------------------------------------------------------------
// hps_vram_wr_buffer
//
// Purpose:
//   Buffers HPS writes to VRAM in a FIFO and commits them to VRAM only inside
//   the vblank window. A one-cycle vram_sync pulse from the PPU snapshots the
//   current occupancy N. Exactly those N entries are then drained, one per
//   cycle and in push order. A one-cycle cpu_vram_wr_irq pulse follows the
//   last committed write.
//
// Handshake:
//   hps_vram_wren is a valid-only strobe with no ready. The write is accepted
//   in the cycle it is asserted if the FIFO is not full. If the FIFO is full
//   the write is dropped and the FIFO contents are left unchanged. The VRAM
//   side is likewise valid-only: vram_wren marks one write per cycle and VRAM
//   is assumed to always accept it.
//
// Ports:
//   clock_clk         in   1  sole clock, rising edge
//   reset_reset       in   1  synchronous active-high reset
//   hps_vram_wraddr   in  13  HPS write word address
//   hps_vram_wren     in   1  HPS write strobe (one write per cycle)
//   hps_vram_wrdata   in  64  HPS write data
//   hps_vram_byteena  in   8  HPS byte enables
//   vram_sync         in   1  vblank-start pulse, opens the commit window
//   vram_wraddr       out 13  VRAM write address (registered)
//   vram_wren         out  1  VRAM write strobe (registered)
//   vram_wrdata       out 64  VRAM write data (registered)
//   vram_byteena      out  8  VRAM byte enables (registered)
//   cpu_vram_wr_irq   out  1  one-cycle pulse, commit finished
//   buf_full          out  1  FIFO holds DEPTH entries
//   buf_overflow      out  1  sticky dropped-write flag
//   dbg_state         out  2  current FSM state (0 IDLE, 1 DRAIN, 2 DONE)
//
// Configuration:
//   DEPTH                      FIFO entry count, a power of 2 from 4 to 64.
//   HPS_VRAM_BUF_OVERFLOW_EN   When this macro is defined, buf_overflow is a
//                              sticky register. It sets on any dropped write
//                              and clears only on reset. When the macro is
//                              undefined, buf_overflow is tied to 0 and no
//                              overflow register exists.
// -----------------------------------------------------------------------------
module hps_vram_wr_buffer #(
  parameter int DEPTH = 16
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic [12:0] hps_vram_wraddr,
  input  logic        hps_vram_wren,
  input  logic [63:0] hps_vram_wrdata,
  input  logic [7:0]  hps_vram_byteena,
  input  logic        vram_sync,
  output logic [12:0] vram_wraddr,
  output logic        vram_wren,
  output logic [63:0] vram_wrdata,
  output logic [7:0]  vram_byteena,
  output logic        cpu_vram_wr_irq,
  output logic        buf_full,
  output logic        buf_overflow,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // FIFO storage. The storage has no reset because emptiness is tracked
  // entirely by the pointers and the occupancy count.
  logic [12:0] mem_addr [DEPTH];
  logic [63:0] mem_data [DEPTH];
  logic [7:0]  mem_be   [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   occ_q, occ_d;
  logic [AW:0]   drain_q, drain_d;

  logic push;
  logic pop;

  assign buf_full  = (occ_q == (AW+1)'(DEPTH));
  assign push      = hps_vram_wren & ~buf_full;
  assign dbg_state = state_q;

  // ---------------------------------------------------------------------------
  // FSM: the state register and the drain counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // The drain count is frozen at the sync-time occupancy. Writes that are
  // pushed during DRAIN therefore stay in the FIFO until the next window.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vram_sync) begin
          if (occ_q != '0) begin
            drain_d = occ_q;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        pop     = 1'b1;
        drain_d = drain_q - (AW+1)'(1);
        if (drain_q == (AW+1)'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clock_clk) begin
    if (push && !reset_reset) begin
      mem_addr[wr_ptr_q] <= hps_vram_wraddr;
      mem_data[wr_ptr_q] <= hps_vram_wrdata;
      mem_be[wr_ptr_q]   <= hps_vram_byteena;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered VRAM port and the completion pulse
  // ---------------------------------------------------------------------------
  // The DONE state is entered in the same cycle that the last write is
  // presented. Registering the pulse places the irq one cycle after the last
  // vram_wren.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      vram_wren       <= 1'b0;
      vram_wraddr     <= '0;
      vram_wrdata     <= '0;
      vram_byteena    <= '0;
      cpu_vram_wr_irq <= 1'b0;
    end else begin
      vram_wren       <= pop;
      cpu_vram_wr_irq <= (state_q == ST_DONE);
      if (pop) begin
        vram_wraddr  <= mem_addr[rd_ptr_q];
        vram_wrdata  <= mem_data[rd_ptr_q];
        vram_byteena <= mem_be[rd_ptr_q];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow flag
  // ---------------------------------------------------------------------------
`ifdef HPS_VRAM_BUF_OVERFLOW_EN
  logic overflow_q;

  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      overflow_q <= 1'b0;
    end else if (hps_vram_wren && buf_full) begin
      overflow_q <= 1'b1;
    end
  end

  assign buf_overflow = overflow_q;
`else
  assign buf_overflow = 1'b0;
`endif

endmodule

// File: doc/hps_vram_wr_buffer.md
HPS_VRAM_WR_BUFFER -- requirements
Module: hps_vram_wr_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count (power of 2, 4..64).
REQ-002 SHALL have port clock_clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset_reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port hps_vram_wraddr  in  13  HPS write word address.
REQ-005 SHALL have port hps_vram_wren  in  1  HPS write strobe, one write per asserted cycle.
REQ-006 SHALL have port hps_vram_wrdata  in  64  HPS write data.
REQ-007 SHALL have port hps_vram_byteena  in  8  HPS byte enables.
REQ-008 SHALL have port vram_sync  in  1  one-cycle pulse from PPU at vblank start; commit window opens.
REQ-009 SHALL have port vram_wraddr  out  13  VRAM write address.
REQ-010 SHALL have port vram_wren  out  1  VRAM write strobe.
REQ-011 SHALL have port vram_wrdata  out  64  VRAM write data.
REQ-012 SHALL have port vram_byteena  out  8  VRAM byte enables.
REQ-013 SHALL have port cpu_vram_wr_irq  out  1  one-cycle pulse: commit finished.
REQ-014 SHALL have port buf_full  out  1  FIFO holds DEPTH entries.
REQ-015 SHALL have port buf_overflow  out  1  sticky: write dropped (see Configuration).

Function
REQ-016 SHALL push {addr,data,byteena} into FIFO on every cycle hps_vram_wren=1 and FIFO not full.
REQ-017 SHALL drop a write arriving while full; FIFO contents unchanged.
REQ-018 SHALL implement FSM IDLE -> DRAIN -> DONE -> IDLE.
REQ-019 IDLE: on vram_sync=1 with occupancy N>0, SHALL latch N into drain counter, go DRAIN; with N=0 go directly to DONE.
REQ-020 DRAIN: SHALL pop exactly one entry per cycle, decrement counter, go DONE in the cycle the counter reaches 0.
REQ-021 SHALL register VRAM outputs: entry popped in cycle C appears on vram_* with vram_wren=1 in cycle C+1; vram_wren=0 otherwise.
REQ-022 SHALL commit entries in push order; N entries give N consecutive vram_wren cycles.
REQ-023 Writes pushed during DRAIN SHALL be accepted (push and pop same cycle allowed, occupancy unchanged) and SHALL NOT be committed until the next vram_sync.
REQ-024 DONE: SHALL assert cpu_vram_wr_irq for exactly one cycle, aligned with the cycle after the last vram_wren, then return to IDLE.
REQ-025 vram_sync outside IDLE SHALL be ignored.
REQ-026 Read/write pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH; occupancy log2(DEPTH)+1 bits.
REQ-027 buf_full SHALL reflect occupancy=DEPTH combinationally from registered state.

Reset
REQ-028 reset_reset=1 SHALL empty FIFO, state IDLE, drain counter 0, vram_wren 0, vram_wraddr/wrdata/byteena 0, cpu_vram_wr_irq 0, buf_full 0, buf_overflow 0.
REQ-029 Reset mid-DRAIN SHALL abandon remaining entries with no irq; reset dominates simultaneous wren/vram_sync.

Configuration
REQ-030 With HPS_VRAM_BUF_OVERFLOW_EN defined, buf_overflow SHALL set on any dropped write and clear only on reset.
REQ-031 Without HPS_VRAM_BUF_OVERFLOW_EN, buf_overflow SHALL be constant 0 and no overflow register SHALL exist; drop behaviour unchanged.

Verification
REQ-032 3 writes (addr 0x010,0x011,0x012, data A/B/C, byteena 0xFF), then vram_sync -> vram_wren high 3 consecutive cycles starting sync+2 in order A,B,C; irq pulse one cycle after last.
REQ-033 vram_sync with empty FIFO -> no vram_wren, irq pulse at sync+2.
REQ-034 DEPTH+1 writes back-to-back (DEPTH=16) -> buf_full=1 after 16th, 17th dropped, buf_overflow=1 (0 with macro off); sync commits 16 entries.
REQ-035 2 writes, sync, 1 write during DRAIN -> 2 committed, irq, 3rd committed only after second sync.
REQ-036 Reset asserted 1 cycle into DRAIN of 8 entries -> vram_wren 0 next cycle, no irq, buf_full 0, empty FIFO.
REQ-037 Write with byteena 0x0F, addr 0x1FFF -> committed unchanged (addr 0x1FFF, byteena 0x0F).
